// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal byte FIFO, configurable framing, flow control and break.
// Frame configuration is captured when a byte is popped and held for that whole frame.
module uart_tx_fifo #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  input  logic                         sample_i,
  output logic                         uart_tx_o,
  input  logic                         cts_n_i,
  input  logic                         flow_enable_i,
  input  logic                         break_i,
  input  logic                         write_i,
  input  logic [7:0]                   wr_data_i,
  output logic                         fifo_full_o,
  output logic                         fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         overflow_o,
  output logic                         tx_done_o,
  output logic                         tx_idle_o,
  input  logic [1:0]                   data_length_i,
  input  logic [1:0]                   stop_bits_i,
  input  logic [1:0]                   parity_mode_i,
  input  logic                         parity_enable_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] T_BIT      = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_ONE_HALF = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_TWO      = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      stop_q, stop_d;
  logic [1:0]      pmode_q, pmode_d;
  logic            pen_q, pen_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            idle_q, idle_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            pop, push, tick_adv, tick_last;
  logic [TW-1:0]   tick_lim;
  logic [7:0]      head, len_mask;

  assign uart_tx_o    = tx_q;
  assign tx_done_o    = done_q;
  assign overflow_o   = ovf_q;
  assign tx_idle_o    = idle_q;
  assign fifo_full_o  = full_q;
  assign fifo_empty_o = empty_q;
  assign fifo_count_o = count_q;

  assign head     = mem_q[rd_ptr_q];
  assign len_mask = 8'hFF >> (2'd3 - data_length_i);

  // Next-state, datapath and FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    len_d    = len_q;
    stop_d   = stop_q;
    pmode_d  = pmode_q;
    pen_d    = pen_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    tick_adv = enable_i & sample_i;

    tick_lim = T_BIT;
    if (state_q == S_STOP) begin
      case (stop_q)
        2'd0:    tick_lim = T_BIT;
        2'd1:    tick_lim = T_ONE_HALF;
        default: tick_lim = T_TWO;
      endcase
    end
    tick_last = (tick_q == tick_lim);

    if (enable_i) begin
      case (state_q)
        S_IDLE: begin
          if (break_i) begin
            state_d = S_BREAK;
            tx_d    = 1'b0;
            tick_d  = '0;
          end else if (!empty_q && (!flow_enable_i || !cts_n_i)) begin
            pop     = 1'b1;
            shift_d = head;
            len_d   = data_length_i;
            stop_d  = stop_bits_i;
            pmode_d = parity_mode_i;
            pen_d   = parity_enable_i;
            par_d   = parity_mode_i[0] ^ (^(head & len_mask));
            tick_d  = '0;
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (tick_adv) begin
            if (tick_last) begin
              tick_d  = '0;
              bit_d   = '0;
              tx_d    = shift_q[0];
              state_d = S_DATA;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (tick_adv) begin
            if (tick_last) begin
              tick_d  = '0;
              shift_d = shift_q >> 1;
              if (bit_q == ({1'b0, len_q} + 3'd4)) begin
                if (pen_q) begin
                  state_d = S_PARITY;
                  tx_d    = pmode_q[1] ? ~pmode_q[0] : par_q;
                end else begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
                end
              end else begin
                bit_d = bit_q + 3'd1;
                tx_d  = shift_q[1];
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_PARITY: begin
          if (tick_adv) begin
            if (tick_last) begin
              tick_d  = '0;
              tx_d    = 1'b1;
              state_d = S_STOP;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_STOP: begin
          if (tick_adv) begin
            if (tick_last) begin
              tick_d  = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_BREAK: begin
          // Line low while requested; the high recovery bit is timed only once the line is back up
          if (break_i) begin
            tx_d   = 1'b0;
            tick_d = '0;
          end else if (!tx_q) begin
            tx_d   = 1'b1;
            tick_d = '0;
          end else if (tick_adv) begin
            if (tick_last) begin
              tick_d  = '0;
              state_d = S_IDLE;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    push     = write_i & (~full_q | pop);
    ovf_d    = write_i & full_q & ~pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    idle_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      len_q    <= '0;
      stop_q   <= '0;
      pmode_q  <= '0;
      pen_q    <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      idle_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      len_q    <= len_d;
      stop_q   <= stop_d;
      pmode_q  <= pmode_d;
      pen_q    <= pen_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      idle_q   <= idle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
